// File: rtl/sfifo_if.sv
// Handshake/status bundle for sfifo: the producer/consumer side drives the
// master modport, the FIFO itself sits on the slave modport.
interface sfifo_if #(
  parameter int unsigned n = 8,
  parameter int unsigned m = 512
);
  localparam int unsigned LW = $clog2(m) + 1;

  logic          wr_en;
  logic [n-1:0]  data;
  logic          rd_en;
  logic          clr_err;
  logic [n-1:0]  data_o;
  logic          empty;
  logic          full;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          almost_empty;
  logic [2:0]    status;
  logic          ovf;
  logic          unf;

  modport master (
    output wr_en, data, rd_en, clr_err,
    input  data_o, empty, full, level, almost_full, almost_empty, status, ovf, unf
  );

  modport slave (
    input  wr_en, data, rd_en, clr_err,
    output data_o, empty, full, level, almost_full, almost_empty, status, ovf, unf
  );
endinterface

// File: rtl/sfifo.sv
// Single-clock first-word-fall-through FIFO on block RAM with registered level,
// threshold flags, fill-band status and sticky overflow/underflow flags.
module sfifo #(
  parameter int unsigned n  = 8,
  parameter int unsigned m  = 512,
  parameter int unsigned af = m - 4,
  parameter int unsigned ae = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  sfifo_if.slave bus
);
  localparam int unsigned AW = $clog2(m);
  localparam int unsigned LW = AW + 1;

  logic [n-1:0]  mem [m];
  logic [LW-1:0] wptr, rptr, rptr_nxt, level;
  logic [n-1:0]  ram_q, byp_q;
  logic          use_byp;
  logic          wr_acc, rd_acc, empty_i, full_i;

  assign empty_i  = (level == '0);
  assign full_i   = (level == LW'(m));
  assign wr_acc   = bus.wr_en & (~full_i | bus.rd_en);
  assign rd_acc   = bus.rd_en & ~empty_i;
  assign rptr_nxt = rptr + LW'(rd_acc);

  // RAM port kept free of reset/enables so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr[AW-1:0]] <= bus.data;
  end

  // Read address tracks the next head, so ram_q already holds it after the edge.
  always_ff @(posedge clk) begin
    ram_q <= mem[rptr_nxt[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      use_byp <= 1'b0;
      byp_q   <= '0;
      bus.ovf <= 1'b0;
      bus.unf <= 1'b0;
    end else begin
      wptr  <= wptr + LW'(wr_acc);
      rptr  <= rptr_nxt;
      byp_q <= bus.data;
      // New head is being written this same edge: RAM read would be stale.
      use_byp <= wr_acc && (wptr[AW-1:0] == rptr_nxt[AW-1:0]);
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (bus.wr_en && !wr_acc) bus.ovf <= 1'b1;
      else if (bus.clr_err)     bus.ovf <= 1'b0;
      if (bus.rd_en && !rd_acc) bus.unf <= 1'b1;
      else if (bus.clr_err)     bus.unf <= 1'b0;
    end
  end

  always_comb begin
    bus.status = 3'd0;
    if (empty_i)                      bus.status = 3'd0;
    else if (full_i)                  bus.status = 3'd5;
    else if (level < LW'(m / 4))      bus.status = 3'd1;
    else if (level < LW'(m / 2))      bus.status = 3'd2;
    else if (level < LW'(3 * m / 4))  bus.status = 3'd3;
    else                              bus.status = 3'd4;
  end

  assign bus.data_o       = empty_i ? '0 : (use_byp ? byp_q : ram_q);
  assign bus.empty        = empty_i;
  assign bus.full         = full_i;
  assign bus.level        = level;
  assign bus.almost_full  = (level >= LW'(af));
  assign bus.almost_empty = (level <= LW'(ae));
endmodule

// File: tb/tb_sfifo.sv
// Directed bench for sfifo (n=8, m=16, af=12, ae=2) with hand-computed expectations.
module tb_sfifo;
  logic clk = 1'b0;
  logic rst_n;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  sfifo_if #(.n(8), .m(16)) bus ();

  sfifo #(.n(8), .m(16), .af(12), .ae(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_err = 1'b0; bus.data = '0;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wr_en = 1'b1; bus.data = d;
    step();
    idle();
  endtask

  task automatic rd();
    bus.rd_en = 1'b1;
    step();
    idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".level"}, 32'(bus.level), 32'd0);
    check({tag, ".data_o"}, 32'(bus.data_o), 32'h0);
    check({tag, ".empty"}, 32'(bus.empty), 32'd1);
    check({tag, ".full"}, 32'(bus.full), 32'd0);
    check({tag, ".ae"}, 32'(bus.almost_empty), 32'd1);
    check({tag, ".af"}, 32'(bus.almost_full), 32'd0);
    check({tag, ".status"}, 32'(bus.status), 32'd0);
    check({tag, ".ovf"}, 32'(bus.ovf), 32'd0);
    check({tag, ".unf"}, 32'(bus.unf), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] v;
    int unsigned wcnt;

    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check_reset("rst");

    // Three consecutive writes
    wr(8'h11);
    check("w1.data_o", 32'(bus.data_o), 32'h11);
    check("w1.empty", 32'(bus.empty), 32'd0);
    check("w1.level", 32'(bus.level), 32'd1);
    check("w1.status", 32'(bus.status), 32'd1);
    check("w1.ae", 32'(bus.almost_empty), 32'd1);
    wr(8'h22);
    check("w2.data_o", 32'(bus.data_o), 32'h11);
    wr(8'h33);
    check("w3.level", 32'(bus.level), 32'd3);
    check("w3.ae", 32'(bus.almost_empty), 32'd0);
    check("w3.data_o", 32'(bus.data_o), 32'h11);
    rd();
    check("r1.data_o", 32'(bus.data_o), 32'h22);
    check("r1.level", 32'(bus.level), 32'd2);

    // Fill to full, then overflow
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      if (i == 3)  check("f4.status", 32'(bus.status), 32'd2);
      if (i == 10) check("f11.af", 32'(bus.almost_full), 32'd0);
      if (i == 11) begin
        check("f12.af", 32'(bus.almost_full), 32'd1);
        check("f12.status", 32'(bus.status), 32'd4);
        check("f12.level", 32'(bus.level), 32'd12);
      end
    end
    check("f16.full", 32'(bus.full), 32'd1);
    check("f16.status", 32'(bus.status), 32'd5);
    check("f16.ovf", 32'(bus.ovf), 32'd0);
    check("f16.data_o", 32'(bus.data_o), 32'h00);
    wr(8'hEE);
    check("f17.level", 32'(bus.level), 32'd16);
    check("f17.ovf", 32'(bus.ovf), 32'd1);
    check("f17.data_o", 32'(bus.data_o), 32'h00);

    // Read+write while full
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.data = 8'hAA;
    step();
    idle();
    check("rw_full.level", 32'(bus.level), 32'd16);
    check("rw_full.full", 32'(bus.full), 32'd1);
    check("rw_full.data_o", 32'(bus.data_o), 32'h01);
    check("rw_full.ovf", 32'(bus.ovf), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      v = (i == 16) ? 8'hAA : 8'(i);
      check($sformatf("drain%0d", i), 32'(bus.data_o), 32'(v));
      rd();
    end
    check("drain.empty", 32'(bus.empty), 32'd1);
    check("drain.data_o", 32'(bus.data_o), 32'h0);
    check("drain.unf", 32'(bus.unf), 32'd0);

    // Read+write while empty
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.data = 8'h5C;
    step();
    idle();
    check("rw_empty.unf", 32'(bus.unf), 32'd1);
    check("rw_empty.level", 32'(bus.level), 32'd1);
    check("rw_empty.data_o", 32'(bus.data_o), 32'h5C);
    bus.clr_err = 1'b1;
    step();
    idle();
    check("clr.unf", 32'(bus.unf), 32'd0);
    check("clr.ovf", 32'(bus.ovf), 32'd0);
    check("clr.data_o", 32'(bus.data_o), 32'h5C);
    rd();
    check("last.empty", 32'(bus.empty), 32'd1);
    // Rejection on the same edge as clr_err keeps the flag set
    bus.clr_err = 1'b1; bus.rd_en = 1'b1;
    step();
    idle();
    check("clr_vs_rej.unf", 32'(bus.unf), 32'd1);
    bus.clr_err = 1'b1;
    step();
    idle();
    check("clr2.unf", 32'(bus.unf), 32'd0);

    // 40 writes / 40 reads, pointers wrap twice
    do_reset();
    wcnt = 0;
    for (int i = 0; i < 3; i++) begin
      v = 8'(wcnt * 7 + 3);
      q.push_back(v);
      wr(v);
      wcnt++;
    end
    for (int i = 0; i < 37; i++) begin
      v = 8'(wcnt * 7 + 3);
      check($sformatf("wrap.head%0d", i), 32'(bus.data_o), 32'(q[0]));
      bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.data = v;
      step();
      idle();
      void'(q.pop_front());
      q.push_back(v);
      wcnt++;
    end
    check("wrap.level", 32'(bus.level), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wrap.tail%0d", i), 32'(bus.data_o), 32'(q[0]));
      void'(q.pop_front());
      rd();
    end
    check("wrap.empty", 32'(bus.empty), 32'd1);
    check("wrap.ovf", 32'(bus.ovf), 32'd0);
    check("wrap.unf", 32'(bus.unf), 32'd0);

    // Reset mid-operation at level 7, with write/read/clr_err also asserted
    for (int i = 0; i < 7; i++) wr(8'(8'h40 + i));
    check("pre_rst.level", 32'(bus.level), 32'd7);
    check("pre_rst.data_o", 32'(bus.data_o), 32'h40);
    rst_n = 1'b0; bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.clr_err = 1'b1; bus.data = 8'h99;
    step();
    idle();
    rst_n = 1'b1;
    check_reset("mid_rst");
    wr(8'h77);
    check("post_rst.data_o", 32'(bus.data_o), 32'h77);
    check("post_rst.level", 32'(bus.level), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sfifo.md
SFIFO -- requirements
Module: sfifo

Interface
REQ-001 Parameter n, default 8, data width in bits; any value 1..32 SHALL be supported.
REQ-002 Parameter m, default 512, depth in words; SHALL be a power of 2, at least 4.
REQ-003 Parameter af, default m-4, almost-full threshold in words, 1..m.
REQ-004 Parameter ae, default 4, almost-empty threshold in words, 0..m-1.
REQ-005 clk  input  1  single clock; all state changes on posedge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 wr_en  input  1  write request; data is stored on the posedge if accepted.
REQ-008 data  input  n  write data.
REQ-009 rd_en  input  1  read request; discards the head word on the posedge if accepted.
REQ-010 data_o  output  n  head (oldest) word, first-word-fall-through; 0 while empty.
REQ-011 empty  output  1  level == 0.
REQ-012 full  output  1  level == m.
REQ-013 level  output  clog2(m)+1  number of stored words, 0..m.
REQ-014 almost_full  output  1  level >= af.
REQ-015 almost_empty  output  1  level <= ae.
REQ-016 status  output  3  000 empty; 001 <m/4; 010 <m/2; 011 <3m/4; 100 <m; 101 full.
REQ-017 ovf  output  1  sticky: a write was rejected.
REQ-018 unf  output  1  sticky: a read was rejected.
REQ-019 clr_err  input  1  synchronously clears ovf and unf.

Function
REQ-020 Write accept = wr_en & (!full | rd_en); read accept = rd_en & !empty.
- Capacity SHALL be exactly m words.
REQ-021 Pointers SHALL be clog2(m)+1 bits wide and wrap modulo 2m; level = wptr - rptr.
- Storage SHALL be indexed by the low clog2(m) pointer bits.
REQ-022 Level update per edge:
- +1 on write only; -1 on read only.
- Unchanged on both or neither.
REQ-023 Write latency: a word accepted into an empty FIFO SHALL appear on data_o, with empty=0, immediately after that edge.
REQ-024 After an accepted read, data_o SHALL show the next oldest word immediately after the edge, or 0 with empty=1 if none remain.
REQ-025 data_o SHALL hold steady between accepted reads.
- A write into a non-empty FIFO SHALL NOT change data_o.
REQ-026 Simultaneous read and write when full: both SHALL be accepted; level stays m, full stays 1.
REQ-027 Simultaneous read and write when empty:
- The write SHALL be accepted and the read rejected.
- unf is set; level becomes 1.
REQ-028 Rejected write: storage and pointers unchanged; ovf set to 1 after the edge.
REQ-029 Rejected read: pointers and data_o unchanged; unf set to 1 after the edge.
REQ-030 clr_err=1 SHALL clear ovf/unf at the edge.
- A rejection on the same edge SHALL win, leaving the flag at 1.
REQ-031 empty, full, almost_*, and status SHALL be combinational decodes of the registered level.
- They SHALL be glitch-free relative to clk edges.
REQ-032 Storage SHALL map onto iCE40 block RAM.
- Head-word prefetch logic SHALL hide the RAM read latency so that REQ-023/024 hold.

Reset
REQ-033 While rst_n=0 at a posedge, the following SHALL be set:
- pointers 0, level 0, data_o 0;
- empty 1, full 0, almost_empty 1, almost_full 0;
- status 000, ovf 0, unf 0.
REQ-034 Reset SHALL take priority over wr_en, rd_en and clr_err.
- Reset mid-operation discards all stored words; RAM contents need not be cleared.

Verification (bench uses n=8, m=16, af=12, ae=2)
REQ-035 Reset, then write 0x11, 0x22, 0x33 on consecutive edges.
- After the first edge: data_o=0x11, empty=0, level=1, status=001.
- After the third edge: level=3, almost_empty=0.
REQ-036 Fill with 0x00..0x0F.
- After the 12th write: almost_full=1, status=100.
- After the 16th: full=1, status=101.
- A 17th write leaves level=16 and sets ovf=1.
REQ-037 With the FIFO full, assert wr_en=rd_en with data=0xAA for one edge.
- Result: level=16, data_o=0x01, ovf unchanged.
- Draining all 16 words yields 0x01..0x0F then 0xAA.
REQ-038 With the FIFO empty, assert rd_en=wr_en with data=0x5C.
- Result: unf=1, level=1, data_o=0x5C.
- clr_err then clears unf.
REQ-039 Run 40 writes and 40 interleaved reads so the pointers wrap twice.
- Output order SHALL match input order.
- Pulse rst_n low at level=7: all outputs reach reset values after that edge.
